// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receive control slice.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    RECEIVE  = 2'd2,
    STOP_CHK = 2'd3
  } state_t;

  // Level of the serial line when nothing is being sent.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for the asynchronous serial line plus a one-cycle
// history flop, giving a clean sampled line and a falling-edge pulse.
module rx_sync_edge
  import rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic s_in,
  output logic start_det
);

  logic sync_1;
  logic sync_2;
  logic prev;

  // Flops come out of reset at the idle line level so no false edge is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= LINE_IDLE;
      sync_2 <= LINE_IDLE;
      prev   <= LINE_IDLE;
    end else begin
      sync_1 <= serial_in;
      sync_2 <= sync_1;
      prev   <= sync_2;
    end
  end

  assign s_in      = sync_2;
  assign start_det = prev & ~sync_2;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive control unit: detects the start bit, drives the bit timer clear and
// enable, shifts in LSB-first data, checks the stop bit and hands the byte to
// the consumer through a data_ready/data_read handshake.
module uart_rx_ctrl
  import rx_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 shift_strobe,
  input  logic                 packet_done,
  input  logic                 data_read,
  output logic                 timer_clear,
  output logic                 timer_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error
);

  state_t               state;
  state_t               next_state;
  logic                 s_in;
  logic                 start_det;
  logic [DATA_BITS:0]   sr;
  logic                 stop_good;

  rx_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .s_in      (s_in),
    .start_det (start_det)
  );

  // Top bit of the shift register holds the stop sample after a full frame.
  assign stop_good = sr[DATA_BITS];

  // Next-state logic; START and STOP_CHK are always single-cycle states.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_det) next_state = START;
      START:    next_state = RECEIVE;
      RECEIVE:  if (packet_done) next_state = STOP_CHK;
      STOP_CHK: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // State register; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Shift register samples the line on each bit-timer strobe, including the
  // strobe that coincides with packet_done, so the stop sample lands in the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '1;
    end else if (state == RECEIVE && shift_strobe) begin
      sr <= {s_in, sr[DATA_BITS:1]};
    end
  end

  // Output byte and status flags; a good-frame load takes priority over a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (state == START) begin
        framing_error <= 1'b0;
      end
      if (state == STOP_CHK) begin
        if (stop_good) begin
          rx_data    <= sr[DATA_BITS-1:0];
          data_ready <= 1'b1;
          if (data_ready && !data_read) begin
            overrun_error <= 1'b1;
          end
        end else begin
          framing_error <= 1'b1;
        end
      end
    end
  end

  // Counter controls are decoded straight from the state (Moore).
  assign timer_clear  = (state == START);
  assign timer_enable = (state == RECEIVE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a table of frame/read vectors with
// hand-computed results plus hand-written reset, timing and ignore sequences.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       shift_strobe;
  logic       packet_done;
  logic       data_read;
  logic       timer_clear;
  logic       timer_enable;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic       is_read;
    logic [7:0] data;
    logic       stop_bit;
    logic       read_at_stop;
    logic       check_timing;
    logic [7:0] exp_rx;
    logic       exp_ready;
    logic       exp_fe;
    logic       exp_oe;
  } vec_t;

  vec_t vecs[10];

  uart_rx_ctrl #(.DATA_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .shift_strobe  (shift_strobe),
    .packet_done   (packet_done),
    .data_read     (data_read),
    .timer_clear   (timer_clear),
    .timer_enable  (timer_enable),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] e_rx, input logic e_rdy,
                          input logic e_fe, input logic e_oe);
    checkOutput({tag, " rx_data"},       rx_data,                e_rx);
    checkOutput({tag, " data_ready"},    {7'd0, data_ready},     {7'd0, e_rdy});
    checkOutput({tag, " framing_error"}, {7'd0, framing_error},  {7'd0, e_fe});
    checkOutput({tag, " overrun_error"}, {7'd0, overrun_error},  {7'd0, e_oe});
  endtask

  // Drives one complete frame: start bit, DATA bits LSB-first, stop bit,
  // one strobe per bit with packet_done on the last strobe.
  task automatic sendFrame(input logic [7:0] data, input logic stop_bit, input logic read_at_stop,
                           input logic check_timing, input logic prev_fe);
    logic bit_val;
    serial_in = 1'b1;
    repeat (4) tick();
    serial_in = 1'b0;
    tick();
    if (check_timing) checkOutput("clear edge1", {7'd0, timer_clear}, 8'd0);
    tick();
    if (check_timing) checkOutput("clear edge2", {7'd0, timer_clear}, 8'd0);
    tick();
    if (check_timing) begin
      checkOutput("clear edge3",  {7'd0, timer_clear},   8'd1);
      checkOutput("enable edge3", {7'd0, timer_enable},  8'd0);
      checkOutput("fe in START",  {7'd0, framing_error}, {7'd0, prev_fe});
    end
    tick();
    if (check_timing) begin
      checkOutput("clear edge4",  {7'd0, timer_clear},   8'd0);
      checkOutput("enable edge4", {7'd0, timer_enable},  8'd1);
      checkOutput("fe after START", {7'd0, framing_error}, 8'd0);
    end
    for (int i = 0; i < 9; i++) begin
      bit_val   = (i < 8) ? data[i] : stop_bit;
      serial_in = bit_val;
      repeat (3) tick();
      if (check_timing && i == 4) checkOutput("enable mid-frame", {7'd0, timer_enable}, 8'd1);
      shift_strobe = 1'b1;
      packet_done  = (i == 8);
      tick();
      shift_strobe = 1'b0;
      packet_done  = 1'b0;
    end
    if (check_timing) checkOutput("enable in STOP_CHK", {7'd0, timer_enable}, 8'd0);
    data_read = read_at_stop;
    tick();
    data_read = 1'b0;
    serial_in = 1'b1;
  endtask

  // Applies one table vector: either a whole frame or a single data_read pulse.
  task automatic applyStimulus(input vec_t v, input logic prev_fe);
    if (v.is_read) begin
      data_read = 1'b1;
      tick();
      data_read = 1'b0;
    end else begin
      sendFrame(v.data, v.stop_bit, v.read_at_stop, v.check_timing, prev_fe);
    end
  endtask

  initial begin
    //          read  data   stop rdStop timing  exp_rx rdy fe oe
    vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1,  8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0,  8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0,  8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b1,  8'h11, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h22, 1'b1, 1'b0, 1'b0,  8'h22, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0,  8'h22, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'hC3, 1'b1, 1'b0, 1'b0,  8'hC3, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0,  8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0,  8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0,  8'h5A, 1'b0, 1'b0, 1'b0};

    rst          = 1'b1;
    serial_in    = 1'b1;
    shift_strobe = 1'b0;
    packet_done  = 1'b0;
    data_read    = 1'b0;
    repeat (2) tick();
    checkAll("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset timer_clear",  {7'd0, timer_clear},  8'd0);
    checkOutput("reset timer_enable", {7'd0, timer_enable}, 8'd0);
    rst = 1'b0;
    tick();

    $display("[TB] strobes outside RECEIVE");
    shift_strobe = 1'b1;
    packet_done  = 1'b1;
    tick();
    shift_strobe = 1'b0;
    packet_done  = 1'b0;
    tick();
    checkOutput("idle strobe enable", {7'd0, timer_enable}, 8'd0);
    checkOutput("idle strobe clear",  {7'd0, timer_clear},  8'd0);
    checkAll("idle strobe", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], (i > 0) ? vecs[i-1].exp_fe : 1'b0);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_rx, vecs[i].exp_ready, vecs[i].exp_fe, vecs[i].exp_oe);
    end

    $display("[TB] reset mid-frame");
    serial_in = 1'b1;
    repeat (4) tick();
    serial_in = 1'b0;
    repeat (4) tick();
    checkOutput("midframe enable before", {7'd0, timer_enable}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      serial_in = i[0];
      repeat (3) tick();
      shift_strobe = 1'b1;
      tick();
      shift_strobe = 1'b0;
    end
    rst       = 1'b1;
    serial_in = 1'b1;
    tick();
    checkOutput("midframe rst enable", {7'd0, timer_enable}, 8'd0);
    checkOutput("midframe rst clear",  {7'd0, timer_clear},  8'd0);
    checkAll("midframe rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    sendFrame(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    checkAll("after rst frame", 8'hFF, 1'b1, 1'b0, 1'b0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
